ahbl_apb_bridge_mc: RTL and testbench
=====================================

# ahbl_apb_bridge_mc

Multi-slave AHB-Lite to APB bridge. It appears as one AHB-Lite slave and fans out to up to 16 APB slaves through a one-hot PSEL. The slave is chosen by a parametrised HADDR slot field. The bridge adds APB4 byte strobes, a two-cycle AHB ERROR response for slave errors and unmapped slots, and an optional PREADY watchdog. It sits in the processor subsystem between the AHB-Lite matrix and the peripheral APB segment, and generalises the single-slot, fixed-width bridge used in the bus-functional test harness.

## Interface
- NUM_SLAVES, 16, number of APB slots (1..16); PSEL width.
- SEL_LSB, 24, lowest HADDR bit of the 4-bit slot index field HADDR[SEL_LSB+3:SEL_LSB].
- APB_ADDR_WIDTH, 32, PADDR width; PADDR = HADDR[APB_ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 256, ACCESS-cycle limit; used only when the watchdog macro is defined.
- HCLK  in  1  single clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL, HWRITE, HREADYIN  in  1  AHB-Lite slave select, direction, and bus ready.
- HTRANS  in  2  only HTRANS[1] (NONSEQ/SEQ) is significant.
- HSIZE  in  3  0=byte, 1=half, 2=word; larger values are treated as word.
- HADDR  in  32  address-phase address.
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  registered read data.
- HREADYOUT, HRESP  out  1  AHB-Lite response.
- PSEL  out  NUM_SLAVES  one-hot APB select.
- PENABLE, PWRITE  out  1  APB control.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB4 byte strobes.
- PRDATA  in  32, PREADY  in  1, PSLVERR  in  1  APB return path.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADYIN while the state is IDLE, DONE or ERR2. HADDR, HWRITE, HSIZE and the slot index are registered on the accept edge.
- States and transitions:
  - IDLE: on accept, go to LATCH if the slot index is < NUM_SLAVES, otherwise go to ERR1.
  - LATCH: HREADYOUT=0; HWDATA is captured into PWDATA; go to SETUP.
  - SETUP: PSEL[slot]=1, PENABLE=0; go to ACCESS.
  - ACCESS: PSEL and PENABLE held at 1. On PREADY=1, capture PRDATA and go to DONE, or go to ERR1 if PSLVERR=1. With PREADY=0, stay in ACCESS.
  - DONE: HREADYOUT=1, HRESP=0. On accept go to LATCH/ERR1, otherwise go to IDLE.
  - ERR1: HRESP=1, HREADYOUT=0; go to ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Accept is allowed; otherwise go to IDLE.
- PADDR, PWRITE and PSTRB are stable from SETUP until the end of ACCESS. PWDATA is stable from SETUP onward.
- PSTRB:
  - Reads: 0.
  - Byte writes: 1<<HADDR[1:0].
  - Halfword writes: 3<<(2*HADDR[1]).
  - Word writes: 4'hF.
- PSLVERR is sampled only when PREADY=1. HRDATA is loaded only on a successful read and otherwise holds its last value.
- An unmapped slot never asserts any PSEL bit.

## Timing
- Reset values (any state): state IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0; PSTRB=0.
- Reset mid-transfer drops PSEL and PENABLE on the next edge. The pending AHB transfer gets no response.
- Transfer accepted at edge T, with PREADY=1:
  - LATCH at T+1, SETUP at T+2, ACCESS at T+3, DONE at T+4.
  - This gives 3 wait states. Each PREADY-low cycle adds one more.
- Unmapped slot accepted at T: ERR1 at T+1, ERR2 at T+2.
- Back-to-back: a transfer accepted in DONE or ERR2 enters LATCH on the next edge with no idle gap. APB transfers are therefore separated by exactly two non-PSEL cycles (DONE, LATCH).
- With HREADYOUT=0, HSEL/HTRANS are ignored.

## Configuration
- AHBL_APB_BRIDGE_TIMEOUT_EN defined:
  - A counter, cleared on SETUP entry, increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the bridge drops PSEL and PENABLE on that edge and goes to ERR1. A late PREADY is ignored.
- Macro undefined: there is no counter and ACCESS waits indefinitely. The TIMEOUT_CYCLES parameter is accepted but unused.

## Structure
- Package ahbl_apb_pkg holds:
  - the state enum (IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2);
  - HTRANS and HRESP encoding constants;
  - HSIZE codes;
  - the slot-index width constant (4).
- Sub-module ahbl_apb_strb_gen: combinational mapping of (HWRITE, HSIZE, HADDR[1:0]) to PSTRB, instantiated once.

## Test plan
- Word write of 0xA5A51234 to 0x03000010, default parameters, PREADY=1:
  - PSEL=0x0008 from T+2 with PENABLE=0 at T+2 and PENABLE=1 at T+3; PADDR=0x03000010; PSTRB=0xF.
  - HREADYOUT=1 at T+4.
- Read of slot 0 with PREADY low for 3 ACCESS cycles and PRDATA=0xDEADBEEF: ACCESS lasts 4 cycles; HRDATA=0xDEADBEEF with HREADYOUT=1 in DONE at T+7.
- Write completing with PSLVERR=1: HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; HRDATA unchanged.
- NUM_SLAVES=4, access to 0x05000000: PSEL stays 0; ERR1 at T+1, ERR2 at T+2.
- Byte write at address ...2: PSTRB=0x4. Halfword write at ...2: PSTRB=0xC. Back-to-back pair accepted in DONE: second PSEL exactly 2 cycles after the first drops.
- Macro defined, TIMEOUT_CYCLES=16, PREADY stuck at 0: PSEL drops after 16 ACCESS cycles, followed by the two-cycle error. Separately, asserting HRESET during ACCESS gives PSEL=0 and HREADYOUT=1 on the next edge.

Source files
------------

// File: rtl/ahbl_apb_pkg.sv
// Shared types and encodings for the multi-slave AHB-Lite to APB bridge.
package ahbl_apb_pkg;

    localparam int unsigned SLOT_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSetup,
        StAccess,
        StDone,
        StErr1,
        StErr2
    } state_e;

endpackage

// File: rtl/ahbl_apb_strb_gen.sv
// Maps an AHB address-phase (write, size, low address bits) to APB4 byte strobes.
module ahbl_apb_strb_gen
    import ahbl_apb_pkg::*;
(
    input  logic       write_i,
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] strb_o
);

    always_comb begin
        strb_o = 4'h0;
        if (write_i) begin
            case (size_i)
                HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
                HSIZE_HALF: strb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                // Word and anything wider drive every lane.
                default:    strb_o = 4'hF;
            endcase
        end
    end

endmodule

// File: rtl/ahbl_apb_bridge_mc.sv
// AHB-Lite slave fanning out to up to 16 APB4 slaves selected by an HADDR slot field.
// Optional PREADY watchdog enabled by defining AHBL_APB_BRIDGE_TIMEOUT_EN.
module ahbl_apb_bridge_mc
    import ahbl_apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 16,
    parameter int unsigned SEL_LSB        = 24,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic                      HWRITE,
    input  logic                      HREADYIN,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HADDR,
    input  logic [31:0]               HWDATA,
    output logic [31:0]               HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [NUM_SLAVES-1:0]     PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic [3:0]                PSTRB,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    state_e                    state_q, state_d;
    logic [SLOT_W-1:0]         slot_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [3:0]                strb_q;
    logic [3:0]                strb_nxt;
    logic [31:0]               pwdata_q;
    logic [31:0]               hrdata_q;
    logic                      accept;
    logic                      mapped;
    logic                      timeout_hit;

    assign accept = HSEL && HTRANS[1] && HREADYIN &&
                    (state_q inside {StIdle, StDone, StErr2});
    assign mapped = (32'(HADDR[SEL_LSB +: SLOT_W]) < NUM_SLAVES);

    ahbl_apb_strb_gen u_strb_gen (
        .write_i   (HWRITE),
        .size_i    (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .strb_o    (strb_nxt)
    );

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q;

    always_ff @(posedge HCLK) begin
        if (HRESET || state_q == StSetup) begin
            tmo_q <= '0;
        end else if (state_q == StAccess && !PREADY) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Fires on the edge where the stall count would reach the limit.
    assign timeout_hit = (state_q == StAccess) && !PREADY &&
                         (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr2: begin
                if (accept) begin
                    state_d = mapped ? StLatch : StErr1;
                end else begin
                    state_d = StIdle;
                end
            end
            StLatch:  state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (PREADY) begin
                    state_d = PSLVERR ? StErr1 : StDone;
                end else if (timeout_hit) begin
                    state_d = StErr1;
                end
            end
            StErr1:   state_d = StErr2;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= 4'h0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                slot_q  <= HADDR[SEL_LSB +: SLOT_W];
                addr_q  <= HADDR[APB_ADDR_WIDTH-1:0];
                write_q <= HWRITE;
                strb_q  <= strb_nxt;
            end
            if (state_q == StLatch) begin
                pwdata_q <= HWDATA;
            end
            if (state_q == StAccess && PREADY && !PSLVERR && !write_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    // Unmapped slots never reach SETUP/ACCESS, so the decode needs no range guard.
    always_comb begin
        PSEL = '0;
        if (state_q == StSetup || state_q == StAccess) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                PSEL[i] = (slot_q == SLOT_W'(i));
            end
        end
    end

    assign PENABLE   = (state_q == StAccess);
    assign PWRITE    = write_q;
    assign PADDR     = addr_q;
    assign PSTRB     = strb_q;
    assign PWDATA    = pwdata_q;
    assign HRDATA    = hrdata_q;
    assign HREADYOUT = !(state_q inside {StLatch, StSetup, StAccess, StErr1});
    assign HRESP     = (state_q inside {StErr1, StErr2}) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_apb_bridge_mc.sv
// Directed bench for ahbl_apb_bridge_mc: a default instance and a 4-slot instance on shared inputs.
module tb_ahbl_apb_bridge_mc;
    import ahbl_apb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset, hsel, hwrite, hreadyin, pready, pslverr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, prdata;

    logic [31:0] hrdata, paddr, pwdata;
    logic        hreadyout, hresp, penable, pwrite;
    logic [15:0] psel;
    logic [3:0]  pstrb;

    logic [31:0] hrdata4, paddr4, pwdata4;
    logic        hreadyout4, hresp4, penable4, pwrite4;
    logic [3:0]  psel4, pstrb4;

    int n_vec = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahbl_apb_bridge_mc u_dut (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HWRITE(hwrite), .HREADYIN(hreadyin),
        .HTRANS(htrans), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata),
        .HREADYOUT(hreadyout), .HRESP(hresp), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr)
    );

    ahbl_apb_bridge_mc #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) u_dut4 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HWRITE(hwrite), .HREADYIN(hreadyin),
        .HTRANS(htrans), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata4),
        .HREADYOUT(hreadyout4), .HRESP(hresp4), .PSEL(psel4), .PENABLE(penable4),
        .PWRITE(pwrite4), .PADDR(paddr4), .PWDATA(pwdata4), .PSTRB(pstrb4), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Full write transfer with PREADY=1, checking the strobes seen in SETUP.
    task automatic wr_strb(input string tag, input logic [31:0] a, input logic [2:0] s,
                           input logic [3:0] exp);
        addr_phase(a, 1'b1, s);
        tick();
        bus_idle();
        tick();
        check_eq(tag, 32'(pstrb), 32'(exp));
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1; hreadyin = 1'b1; hwrite = 1'b0; hsize = HSIZE_WORD;
        haddr = '0; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        bus_idle();
        tick();
        tick();
        check_eq("rst_hreadyout", 32'(hreadyout), 1);
        check_eq("rst_hresp", 32'(hresp), 0);
        check_eq("rst_hrdata", hrdata, 0);
        check_eq("rst_psel", 32'(psel), 0);
        check_eq("rst_penable", 32'(penable), 0);
        check_eq("rst_pwrite", 32'(pwrite), 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_pstrb", 32'(pstrb), 0);
        hreset = 1'b0;
        tick();

        // Word write to slot 3, zero wait.
        addr_phase(32'h0300_0010, 1'b1, HSIZE_WORD);
        tick();
        bus_idle();
        hwdata = 32'hA5A5_1234;
        check_eq("wr_latch_hready", 32'(hreadyout), 0);
        check_eq("wr_latch_psel", 32'(psel), 0);
        tick();
        check_eq("wr_setup_psel", 32'(psel), 32'h0008);
        check_eq("wr_setup_penable", 32'(penable), 0);
        check_eq("wr_setup_paddr", paddr, 32'h0300_0010);
        check_eq("wr_setup_pstrb", 32'(pstrb), 32'hF);
        check_eq("wr_setup_pwrite", 32'(pwrite), 1);
        check_eq("wr_setup_pwdata", pwdata, 32'hA5A5_1234);
        check_eq("wr_setup_psel4", 32'(psel4), 32'h8);
        hwdata = 32'h0;
        tick();
        check_eq("wr_access_penable", 32'(penable), 1);
        check_eq("wr_access_psel", 32'(psel), 32'h0008);
        check_eq("wr_access_hready", 32'(hreadyout), 0);
        check_eq("wr_access_pwdata", pwdata, 32'hA5A5_1234);
        tick();
        check_eq("wr_done_hready", 32'(hreadyout), 1);
        check_eq("wr_done_hresp", 32'(hresp), 0);
        check_eq("wr_done_psel", 32'(psel), 0);
        tick();

        // Read of slot 0 with three stalled ACCESS cycles.
        pready = 1'b0;
        prdata = 32'hDEAD_BEEF;
        addr_phase(32'h0000_0040, 1'b0, HSIZE_WORD);
        tick();
        bus_idle();
        tick();
        check_eq("rd_setup_psel", 32'(psel), 32'h0001);
        check_eq("rd_setup_pstrb", 32'(pstrb), 0);
        check_eq("rd_setup_pwrite", 32'(pwrite), 0);
        tick();
        tick();
        tick();
        tick();
        check_eq("rd_access4_hready", 32'(hreadyout), 0);
        check_eq("rd_access4_penable", 32'(penable), 1);
        check_eq("rd_access4_hrdata", hrdata, 0);
        pready = 1'b1;
        tick();
        check_eq("rd_done_hrdata", hrdata, 32'hDEAD_BEEF);
        check_eq("rd_done_hready", 32'(hreadyout), 1);
        check_eq("rd_done_hresp", 32'(hresp), 0);
        check_eq("rd_done_hrdata4", hrdata4, 32'hDEAD_BEEF);
        tick();

        // Write completing with PSLVERR.
        pslverr = 1'b1;
        prdata  = 32'h5555_5555;
        addr_phase(32'h0100_0004, 1'b1, HSIZE_WORD);
        tick();
        bus_idle();
        hwdata = 32'h1234_5678;
        tick();
        tick();
        tick();
        check_eq("slverr_err1_hresp", 32'(hresp), 1);
        check_eq("slverr_err1_hready", 32'(hreadyout), 0);
        check_eq("slverr_err1_psel", 32'(psel), 0);
        pslverr = 1'b0;
        tick();
        check_eq("slverr_err2_hresp", 32'(hresp), 1);
        check_eq("slverr_err2_hready", 32'(hreadyout), 1);
        check_eq("slverr_hrdata", hrdata, 32'hDEAD_BEEF);
        tick();

        // Slot 5 is unmapped on the 4-slot instance, mapped on the default one.
        prdata = 32'h0BAD_F00D;
        addr_phase(32'h0500_0000, 1'b0, HSIZE_WORD);
        tick();
        bus_idle();
        check_eq("unmap_err1_hresp4", 32'(hresp4), 1);
        check_eq("unmap_err1_hready4", 32'(hreadyout4), 0);
        check_eq("unmap_err1_psel4", 32'(psel4), 0);
        tick();
        check_eq("unmap_err2_hresp4", 32'(hresp4), 1);
        check_eq("unmap_err2_hready4", 32'(hreadyout4), 1);
        check_eq("unmap_err2_psel4", 32'(psel4), 0);
        check_eq("unmap_setup_psel16", 32'(psel), 32'h0020);
        tick();
        check_eq("unmap_idle_psel4", 32'(psel4), 0);
        check_eq("unmap_idle_hresp4", 32'(hresp4), 0);
        check_eq("unmap_penable4", 32'(penable4), 0);
        tick();
        check_eq("unmap_hrdata4", hrdata4, 32'hDEAD_BEEF);
        tick();

        // Byte write at ...2, then a halfword write accepted in DONE.
        addr_phase(32'h0200_0002, 1'b1, HSIZE_BYTE);
        tick();
        bus_idle();
        hwdata = 32'h00AA_0000;
        tick();
        check_eq("b2b_byte_pstrb", 32'(pstrb), 32'h4);
        check_eq("b2b_byte_psel", 32'(psel), 32'h0004);
        tick();
        tick();
        check_eq("b2b_done_hready", 32'(hreadyout), 1);
        check_eq("b2b_done_psel", 32'(psel), 0);
        addr_phase(32'h0200_0006, 1'b1, HSIZE_HALF);
        tick();
        bus_idle();
        hwdata = 32'hBEEF_0000;
        check_eq("b2b_latch_psel", 32'(psel), 0);
        check_eq("b2b_latch_hready", 32'(hreadyout), 0);
        tick();
        check_eq("b2b_half_psel", 32'(psel), 32'h0004);
        check_eq("b2b_half_pstrb", 32'(pstrb), 32'hC);
        check_eq("b2b_half_paddr", paddr, 32'h0200_0006);
        check_eq("b2b_half_pwdata4", pwdata4, 32'hBEEF_0000);
        tick();
        tick();
        tick();

        wr_strb("strb_byte1", 32'h0100_0001, HSIZE_BYTE, 4'h2);
        wr_strb("strb_byte3", 32'h0100_0003, HSIZE_BYTE, 4'h8);
        wr_strb("strb_half0", 32'h0100_0000, HSIZE_HALF, 4'h3);
        wr_strb("strb_size3", 32'h0100_0001, 3'd3, 4'hF);
        check_eq("strb_pwrite4", 32'(pwrite4), 1);
        check_eq("strb_pstrb4", 32'(pstrb4), 32'hF);
        check_eq("strb_paddr4", paddr4, 32'h0100_0001);

        // Stalled read on slot 1, then reset during ACCESS.
        pready = 1'b0;
        addr_phase(32'h0100_0000, 1'b0, HSIZE_WORD);
        tick();
        bus_idle();
        tick();
        tick();
        check_eq("stall_access_psel", 32'(psel), 32'h0002);
        check_eq("stall_access_penable", 32'(penable), 1);
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
        repeat (15) tick();
        check_eq("tmo_last_psel4", 32'(psel4), 32'h2);
        check_eq("tmo_last_penable4", 32'(penable4), 1);
        tick();
        check_eq("tmo_err1_psel4", 32'(psel4), 0);
        check_eq("tmo_err1_penable4", 32'(penable4), 0);
        check_eq("tmo_err1_hresp4", 32'(hresp4), 1);
        check_eq("tmo_err1_hready4", 32'(hreadyout4), 0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        check_eq("tmo_err2_hresp4", 32'(hresp4), 1);
        check_eq("tmo_err2_hready4", 32'(hreadyout4), 1);
        check_eq("tmo_err2_hrdata4", hrdata4, 32'hDEAD_BEEF);
        check_eq("tmo_dut16_psel", 32'(psel), 32'h0002);
`endif
        hreset = 1'b1;
        tick();
        check_eq("midrst_psel", 32'(psel), 0);
        check_eq("midrst_penable", 32'(penable), 0);
        check_eq("midrst_hready", 32'(hreadyout), 1);
        check_eq("midrst_hresp", 32'(hresp), 0);
        check_eq("midrst_hrdata", hrdata, 0);
        check_eq("midrst_psel4", 32'(psel4), 0);
        check_eq("midrst_hready4", 32'(hreadyout4), 1);
        hreset = 1'b0;
        pready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
